// File: rtl/rca_40b.sv
// rtl/rca_40b.sv - 40-bit ripple-carry adder with registered sum/carry-out.
// Define RCA_40B_OVF_EN to add the registered two's-complement overflow output Ovf.

module rca_40b_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module rca_40b (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] A,
    input  logic [39:0] B,
    input  logic        Cin,
    output logic [39:0] S,
    output logic        Cout
`ifdef RCA_40B_OVF_EN
    ,
    output logic        Ovf
`endif
);
    logic [40:0] w_c;
    logic [39:0] w_s;
    logic [39:0] r_s;
    logic        r_cout;

    assign w_c[0] = Cin;

    // One cell per bit; carry ripples strictly from bit 0 up to bit 39.
    for (genvar i = 0; i < 40; i++) begin : g_fa
        rca_40b_fa u_fa (
            .i_a (A[i]),
            .i_b (B[i]),
            .i_c (w_c[i]),
            .o_s (w_s[i]),
            .o_c (w_c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_s;
            r_cout <= w_c[40];
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;

`ifdef RCA_40B_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) r_ovf <= 1'b0;
        else     r_ovf <= w_c[40] ^ w_c[39];
    end

    assign Ovf = r_ovf;
`endif
endmodule

// File: tb/tb_rca_40b.sv
// tb/tb_rca_40b.sv - scoreboard testbench for rca_40b (covers RCA_40B_OVF_EN when defined).

module tb_rca_40b;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] A = '0;
    logic [39:0] B = '0;
    logic        Cin = 1'b0;
    logic [39:0] S;
    logic        Cout;
`ifdef RCA_40B_OVF_EN
    logic        Ovf;
`endif

    int total = 0;
    int bad   = 0;

    // Expected entry: {ovf, cout, s}
    logic [41:0] sb[$];
    logic [41:0] exp_v;

    localparam logic [39:0] ONES = 40'hFF_FFFF_FFFF;

    always #5 clk = ~clk;

    rca_40b dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
`ifdef RCA_40B_OVF_EN
        .Ovf  (Ovf),
`endif
        .Cout (Cout)
    );

    function automatic logic [41:0] model(input logic r, input logic [39:0] a,
                                          input logic [39:0] b, input logic c);
        logic [40:0] sum;
        logic        ovf;
        if (r) return '0;
        sum = {1'b0, a} + {1'b0, b} + {40'd0, c};
        ovf = (a[39] == b[39]) && (sum[39] != a[39]);
        return {ovf, sum};
    endfunction

    task automatic drive(input logic r, input logic [39:0] a, input logic [39:0] b, input logic c);
        rst = r; A = a; B = b; Cin = c;
        sb.push_back(model(r, a, b, c));
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                total++; if (S !== exp_v[39:0]) begin bad++; $display("FAIL reset S got=%h exp=%h", S, exp_v[39:0]); end
                total++; if (Cout !== exp_v[40]) begin bad++; $display("FAIL reset Cout got=%b exp=%b", Cout, exp_v[40]); end
`ifdef RCA_40B_OVF_EN
                total++; if (Ovf !== exp_v[41]) begin bad++; $display("FAIL reset Ovf got=%b exp=%b", Ovf, exp_v[41]); end
`endif
            end
            if (i == 0)      drive(1'b1, ONES, ONES, 1'b1);
            else if (i == 1) drive(1'b0, ONES, ONES, 1'b1);
            else if (i == 2) drive(1'b0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_directed;
        logic [39:0] ta[9];
        logic [39:0] tb_[9];
        logic        tc[9];
        ta  = '{40'd1, 40'd2, 40'hF, 40'd0, 40'd0, 40'd1, ONES, 40'h7F_FFFF_FFFF, 40'h80_0000_0000};
        tb_ = '{40'd1, 40'd3, 40'd1, ONES,  ONES,  ONES,  ONES, 40'd1,           40'h80_0000_0000};
        tc  = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1, 1'b0,            1'b0};
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                total++; if (S !== exp_v[39:0]) begin bad++; $display("FAIL directed S got=%h exp=%h", S, exp_v[39:0]); end
                total++; if (Cout !== exp_v[40]) begin bad++; $display("FAIL directed Cout got=%b exp=%b", Cout, exp_v[40]); end
`ifdef RCA_40B_OVF_EN
                total++; if (Ovf !== exp_v[41]) begin bad++; $display("FAIL directed Ovf got=%b exp=%b", Ovf, exp_v[41]); end
`endif
            end
            if (i < 9) drive(1'b0, ta[i], tb_[i], tc[i]);
        end
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                total++; if (S !== exp_v[39:0]) begin bad++; $display("FAIL mid_reset S got=%h exp=%h", S, exp_v[39:0]); end
                total++; if (Cout !== exp_v[40]) begin bad++; $display("FAIL mid_reset Cout got=%b exp=%b", Cout, exp_v[40]); end
`ifdef RCA_40B_OVF_EN
                total++; if (Ovf !== exp_v[41]) begin bad++; $display("FAIL mid_reset Ovf got=%b exp=%b", Ovf, exp_v[41]); end
`endif
            end
            if (i == 0)      drive(1'b0, 40'h12_3456_789A, 40'hF0_0000_0001, 1'b1);
            else if (i == 1) drive(1'b1, 40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFF, 1'b1);
            else if (i == 2) drive(1'b0, 40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFF, 1'b1);
        end
    endtask

    task automatic test_back_to_back;
        logic [39:0] ra, rb;
        for (int i = 0; i <= 10000; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                total++; if (S !== exp_v[39:0]) begin bad++; $display("FAIL random S got=%h exp=%h", S, exp_v[39:0]); end
                total++; if (Cout !== exp_v[40]) begin bad++; $display("FAIL random Cout got=%b exp=%b", Cout, exp_v[40]); end
`ifdef RCA_40B_OVF_EN
                total++; if (Ovf !== exp_v[41]) begin bad++; $display("FAIL random Ovf got=%b exp=%b", Ovf, exp_v[41]); end
`endif
            end
            if (i < 10000) begin
                ra = {$urandom_range(255, 0), $urandom()};
                rb = {$urandom_range(255, 0), $urandom()};
                if ($urandom_range(15, 0) == 0) rb = ~ra;
                drive(1'b0, ra, rb, 1'($urandom_range(1, 0)));
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_directed();
        test_mid_reset();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
